bus_activity_monitor: RTL and testbench

BUS_ACTIVITY_MONITOR -- requirements
Module: bus_activity_monitor

---
 rtl/bus_activity_monitor.sv | 127 ++++++++++++
 tb/tb_bus_activity_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_activity_monitor.sv
// bus_activity_monitor
// Measures switching activity on an encoded bus over a fixed window of WIN
// transition samples. It reports the total number of bit toggles, the largest
// single-cycle Hamming distance and the sample count. A sticky flag is set if
// the toggle accumulator clipped.
//
// Ports
//   ck          rising-edge clock
//   rst         asynchronous, active-high reset
//   start       single-cycle request to arm a measurement (IDLE/DONE only)
//   bus_in      encoded bus word under measurement
//   valid_in    bus_in carries a meaningful word this cycle
//   busy        high while armed or running
//   done        high while results are final
//   trans_total accumulated bit transitions (saturating)
//   max_hd      largest single-cycle Hamming distance seen
//   samples     transition samples counted so far (never exceeds WIN)
//   sat         sticky: trans_total clipped at its maximum
//   state       current FSM state, for observation only
//
// Input qualification: bus_in is consumed on every rising edge where
// valid_in=1 while the monitor is in ARM or RUN. There is no back-pressure.
// The monitor is always ready, and words presented outside ARM/RUN are
// silently dropped.
module bus_activity_monitor #(
    parameter int W     = 9,
    parameter int CNT_W = 24,
    parameter int WIN   = 256
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic                       start,
    input  logic [W-1:0]               bus_in,
    input  logic                       valid_in,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           trans_total,
    output logic [$clog2(W+1)-1:0]     max_hd,
    output logic [15:0]                samples,
    output logic                       sat,
    output logic [1:0]                 state
);

    localparam int HD_W = $clog2(W+1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     cur_state;
    logic [W-1:0]   prev;
    logic [W-1:0]   diff;
    logic [HD_W-1:0] hd;
    logic [CNT_W:0] sum;
    logic           last_sample;

    // Hamming distance between the incoming word and the previous one.
    // This is purely combinational so it is usable on the same edge.
    always_comb begin
        diff = bus_in ^ prev;
        hd   = '0;
        for (int i = 0; i < W; i++) begin
            hd = hd + HD_W'(diff[i]);
        end
    end

    // One extra bit catches the carry that signals a clipped addition.
    assign sum         = {1'b0, trans_total} + (CNT_W+1)'(hd);
    assign last_sample = (samples == 16'(WIN - 1));

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            cur_state   <= S_IDLE;
            prev        <= '0;
            trans_total <= '0;
            max_hd      <= '0;
            samples     <= '0;
            sat         <= 1'b0;
        end else begin
            case (cur_state)
                S_IDLE, S_DONE: begin
                    // start has priority over a word arriving in the same cycle.
                    // That word is not captured.
                    if (start) begin
                        cur_state   <= S_ARM;
                        trans_total <= '0;
                        max_hd      <= '0;
                        samples     <= '0;
                        sat         <= 1'b0;
                    end
                end
                S_ARM: begin
                    // The first valid word only seeds the reference value.
                    if (valid_in) begin
                        prev      <= bus_in;
                        cur_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (valid_in) begin
                        prev <= bus_in;
                        if (sum[CNT_W]) begin
                            trans_total <= '1;
                            sat         <= 1'b1;
                        end else begin
                            trans_total <= sum[CNT_W-1:0];
                        end
                        if (hd > max_hd) begin
                            max_hd <= hd;
                        end
                        samples <= samples + 16'd1;
                        if (last_sample) begin
                            cur_state <= S_DONE;
                        end
                    end
                end
                default: cur_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (cur_state == S_ARM) || (cur_state == S_RUN);
    assign done  = (cur_state == S_DONE);
    assign state = cur_state;

endmodule

// File: tb/tb_bus_activity_monitor.sv
// Directed testbench for bus_activity_monitor.
// Two instances share the same stimulus. The main instance has W=9, CNT_W=24
// and WIN=4. The narrow instance has CNT_W=4 so that the saturation path is
// exercised. Inputs change on the falling edge, and outputs are checked on the
// falling edge that follows the capturing rising edge.
module tb_bus_activity_monitor;

    localparam int W     = 9;
    localparam int WIN   = 4;
    localparam int HD_W  = $clog2(W+1);

    // ---------------- clock / reset ----------------
    logic ck = 1'b0;
    logic rst;
    always #5 ck = ~ck;

    logic         start;
    logic [W-1:0] bus_in;
    logic         valid_in;

    logic              busy, done, sat;
    logic [23:0]       trans_total;
    logic [HD_W-1:0]   max_hd;
    logic [15:0]       samples;
    logic [1:0]        state;

    logic              s_busy, s_done, s_sat;
    logic [3:0]        s_trans_total;
    logic [HD_W-1:0]   s_max_hd;
    logic [15:0]       s_samples;
    logic [1:0]        s_state;

    bus_activity_monitor #(.W(W), .CNT_W(24), .WIN(WIN)) dut (
        .ck(ck), .rst(rst), .start(start), .bus_in(bus_in), .valid_in(valid_in),
        .busy(busy), .done(done), .trans_total(trans_total), .max_hd(max_hd),
        .samples(samples), .sat(sat), .state(state)
    );

    bus_activity_monitor #(.W(W), .CNT_W(4), .WIN(WIN)) dut_sat (
        .ck(ck), .rst(rst), .start(start), .bus_in(bus_in), .valid_in(valid_in),
        .busy(s_busy), .done(s_done), .trans_total(s_trans_total), .max_hd(s_max_hd),
        .samples(s_samples), .sat(s_sat), .state(s_state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checks the main instance's results against an expected tuple.
    task automatic check_result(input string tag, input logic [31:0] e_trans,
                                input logic [31:0] e_max, input logic [31:0] e_samp,
                                input logic [31:0] e_sat, input logic [31:0] e_done);
        exp_q.push_back(e_trans);
        exp_q.push_back(e_max);
        exp_q.push_back(e_samp);
        exp_q.push_back(e_sat);
        exp_q.push_back(e_done);
        check({tag, ".trans"},   32'(trans_total), exp_q.pop_front());
        check({tag, ".max_hd"},  32'(max_hd),      exp_q.pop_front());
        check({tag, ".samples"}, 32'(samples),     exp_q.pop_front());
        check({tag, ".sat"},     32'(sat),         exp_q.pop_front());
        check({tag, ".done"},    32'(done),        exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic put(input logic [W-1:0] d, input logic v);
        @(negedge ck);
        start    = 1'b0;
        bus_in   = d;
        valid_in = v;
    endtask

    task automatic pulse_start();
        @(negedge ck);
        start    = 1'b1;
        valid_in = 1'b0;
    endtask

    // Drops all requests and lands on the falling edge after the last capture.
    task automatic settle();
        @(negedge ck);
        start    = 1'b0;
        valid_in = 1'b0;
    endtask

    // Waits a bounded number of cycles for done. An expired bound counts as a failure.
    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 20) begin
            @(negedge ck);
            n++;
        end
        check({tag, ".done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic run_ramp(input string tag);
        pulse_start();
        put(9'h000, 1'b1);
        put(9'h001, 1'b1);
        put(9'h003, 1'b1);
        put(9'h007, 1'b1);
        put(9'h00F, 1'b1);
        settle();
        wait_done(tag);
        check_result(tag, 4, 1, 4, 0, 1);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        bus_in   = '0;
        valid_in = 1'b0;
        repeat (3) @(negedge ck);
        check_result("reset", 0, 0, 0, 0, 0);
        check("reset.busy",  32'(busy),  32'd0);
        check("reset.state", 32'(state), 32'd0);
        rst = 1'b0;
        @(negedge ck);

        // Incrementing thermometer code: 1 bit toggles per sample.
        run_ramp("ramp");

        // Words arriving while in DONE are not counted.
        put(9'h1FF, 1'b1);
        put(9'h000, 1'b1);
        settle();
        check_result("done_hold", 4, 1, 4, 0, 1);

        // A start in DONE clears the results and re-arms the monitor.
        pulse_start();
        settle();
        check_result("rearm", 0, 0, 0, 0, 0);
        check("rearm.busy",  32'(busy),  32'd1);
        check("rearm.state", 32'(state), 32'd1);

        // Full-width toggling. The narrow instance saturates: 9+9 -> 15.
        put(9'h000, 1'b1);
        put(9'h1FF, 1'b1);
        put(9'h000, 1'b1);
        put(9'h1FF, 1'b1);
        put(9'h000, 1'b1);
        settle();
        check_result("alt", 36, 9, 4, 0, 1);
        check("sat.trans",  32'(s_trans_total), 32'd15);
        check("sat.sat",    32'(s_sat),         32'd1);
        check("sat.done",   32'(s_done),        32'd1);
        check("sat.max_hd", 32'(s_max_hd),      32'd9);

        // An invalid cycle in the middle is ignored and the bus value is not captured.
        pulse_start();
        put(9'h000, 1'b1);
        put(9'h1FF, 1'b0);
        put(9'h001, 1'b1);
        put(9'h001, 1'b1);
        put(9'h001, 1'b1);
        put(9'h003, 1'b1);
        settle();
        check_result("gap", 2, 1, 4, 0, 1);
        check("gap.sat_cleared", 32'(s_sat), 32'd0);

        // A start during RUN is ignored. A reset in RUN discards the partial results.
        pulse_start();
        put(9'h000, 1'b1);
        put(9'h001, 1'b1);
        put(9'h003, 1'b1);
        settle();
        check_result("partial", 2, 1, 2, 0, 0);
        pulse_start();
        settle();
        check("run_start.state",   32'(state),   32'd2);
        check("run_start.samples", 32'(samples), 32'd2);
        check("run_start.busy",    32'(busy),    32'd1);
        #1 rst = 1'b1;
        #1;
        check_result("async_rst", 0, 0, 0, 0, 0);
        check("async_rst.busy",  32'(busy),  32'd0);
        check("async_rst.state", 32'(state), 32'd0);
        @(negedge ck);
        rst = 1'b0;
        repeat (6) @(negedge ck);
        check("post_rst.done",  32'(done),  32'd0);
        check("post_rst.state", 32'(state), 32'd0);
        run_ramp("after_rst");

        // start and valid together in DONE: start wins and 0x0FF is not the reference.
        @(negedge ck);
        start    = 1'b1;
        valid_in = 1'b1;
        bus_in   = 9'h0FF;
        put(9'h000, 1'b1);
        put(9'h001, 1'b1);
        put(9'h003, 1'b1);
        put(9'h007, 1'b1);
        put(9'h00F, 1'b1);
        settle();
        check_result("start_wins", 4, 1, 4, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guards against the run hanging.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
